// File: rtl/downstream_cancel_tracker_pkg.sv
// cache_def: shared state and mode types for the downstream cancel tracker.
package cache_def;

    typedef enum logic [2:0] {INIT, IDLE, URD, UWR, QRD} tracker_state_e;

    typedef enum logic {MODE_OVERWRITE = 1'b0, MODE_ACCUM = 1'b1} tracker_mode_e;

endpackage

// File: rtl/dm_ram_param.sv
// dm_ram_param: synchronous single-port RAM with registered read data.
module dm_ram_param #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/downstream_cancel_tracker.sv
// downstream_cancel_tracker: per-client cancelled-amount table with update/query ports,
// duplicate suppression and a zeroing sweep after reset.
module downstream_cancel_tracker
    import cache_def::*;
#(
    parameter int NUM_CLIENTS = 32,
    parameter int CLIENT_W    = $clog2(NUM_CLIENTS),
    parameter int AMOUNT_W    = 16,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [CLIENT_W-1:0] upd_client,
    input  logic [AMOUNT_W-1:0] upd_amount,
    input  logic                upd_mode,
    input  logic                qry_valid,
    output logic                qry_ready,
    input  logic [CLIENT_W-1:0] qry_client,
    output logic                rsp_valid,
    output logic [CLIENT_W-1:0] rsp_client,
    output logic [AMOUNT_W-1:0] rsp_amount,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    dup_cnt,
    output logic                init_done
);

    typedef struct packed {
        logic [CLIENT_W-1:0] client;
        logic [AMOUNT_W-1:0] amount;
        tracker_mode_e       mode;
    } upd_req_t;

    localparam logic [CLIENT_W-1:0] LAST  = CLIENT_W'(NUM_CLIENTS - 1);
    localparam logic [CLIENT_W:0]   NUM_W = (CLIENT_W + 1)'(NUM_CLIENTS);

    tracker_state_e      state, state_nx;
    upd_req_t            req;
    logic                last_valid;
    logic [CLIENT_W-1:0] last_client, idx, addr;
    logic [AMOUNT_W-1:0] last_amount, rdata, wdata;
    logic [AMOUNT_W:0]   sum;
    logic                we, upd_fire, qry_fire, upd_oor, qry_oor, dup;

    assign upd_ready = state == IDLE;
    assign qry_ready = state == IDLE && !upd_valid;
    assign upd_fire  = upd_valid && upd_ready;
    assign qry_fire  = qry_valid && qry_ready;
    assign upd_oor   = {1'b0, upd_client} >= NUM_W;
    assign qry_oor   = {1'b0, qry_client} >= NUM_W;
    assign dup       = !upd_mode && last_valid && upd_client == last_client && upd_amount == last_amount;

    // Queries read straight from the port in IDLE so the data is registered by the end of QRD.
    assign addr  = state == INIT ? idx : state == IDLE ? qry_client : req.client;
    assign we    = state == INIT || state == UWR;
    assign sum   = {1'b0, rdata} + {1'b0, req.amount};
    assign wdata = state == INIT ? '0
                 : req.mode == MODE_ACCUM ? (sum[AMOUNT_W] ? '1 : sum[AMOUNT_W-1:0])
                 : req.amount;

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (idx == LAST) state_nx = IDLE;
            IDLE:    state_nx = upd_fire ? (upd_oor || dup ? IDLE : URD) : qry_fire && !qry_oor ? QRD : IDLE;
            URD:     state_nx = UWR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            idx         <= '0;
            req         <= '0;
            last_valid  <= 1'b0;
            last_client <= '0;
            last_amount <= '0;
            dup_cnt     <= '0;
            err_pulse   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_client  <= '0;
            rsp_amount  <= '0;
            init_done   <= 1'b0;
        end else begin
            state     <= state_nx;
            err_pulse <= (upd_fire && upd_oor) || (qry_fire && qry_oor);
            rsp_valid <= state == QRD;
            if (state == QRD) begin
                rsp_client <= req.client;
                rsp_amount <= rdata;
            end
            if (state == INIT) begin
                idx <= idx + 1'b1;
                if (idx == LAST) init_done <= 1'b1;
            end
            if (upd_fire && !upd_oor) begin
                if (dup) begin
                    dup_cnt <= &dup_cnt ? dup_cnt : dup_cnt + 1'b1;
                end else begin
                    req         <= '{client: upd_client, amount: upd_amount, mode: tracker_mode_e'(upd_mode)};
                    last_valid  <= 1'b1;
                    last_client <= upd_client;
                    last_amount <= upd_amount;
                end
            end
            if (qry_fire) req.client <= qry_client;
        end
    end

    dm_ram_param #(.DEPTH(NUM_CLIENTS), .WIDTH(AMOUNT_W), .ADDR_W(CLIENT_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_downstream_cancel_tracker.sv
// tb_downstream_cancel_tracker: directed stimulus against a transaction-level table model.
module tb_downstream_cancel_tracker;

    localparam int N = 32;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        upd_valid = 1'b0, upd_mode = 1'b0, qry_valid = 1'b0;
    logic [4:0]  upd_client = '0, qry_client = '0;
    logic [15:0] upd_amount = '0;
    logic        upd_ready, qry_ready, rsp_valid, err_pulse, init_done;
    logic [4:0]  rsp_client;
    logic [15:0] rsp_amount, dup_cnt;

    logic        u2_upd_valid = 1'b0, u2_qry_valid = 1'b0;
    logic [4:0]  u2_upd_client = '0, u2_qry_client = '0;
    logic [15:0] u2_upd_amount = '0;
    logic        u2_upd_ready, u2_qry_ready, u2_rsp_valid, u2_err_pulse, u2_init_done;
    logic [4:0]  u2_rsp_client;
    logic [15:0] u2_rsp_amount, u2_dup_cnt;

    int checks = 0, errors = 0, d_writes = 0;

    always #5 clk = ~clk;

    downstream_cancel_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_client(upd_client),
        .upd_amount(upd_amount), .upd_mode(upd_mode),
        .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_client(qry_client),
        .rsp_valid(rsp_valid), .rsp_client(rsp_client), .rsp_amount(rsp_amount),
        .err_pulse(err_pulse), .dup_cnt(dup_cnt), .init_done(init_done)
    );

    downstream_cancel_tracker #(.NUM_CLIENTS(20)) dut20 (
        .clk(clk), .rst_n(rst_n),
        .upd_valid(u2_upd_valid), .upd_ready(u2_upd_ready), .upd_client(u2_upd_client),
        .upd_amount(u2_upd_amount), .upd_mode(1'b0),
        .qry_valid(u2_qry_valid), .qry_ready(u2_qry_ready), .qry_client(u2_qry_client),
        .rsp_valid(u2_rsp_valid), .rsp_client(u2_rsp_client), .rsp_amount(u2_rsp_amount),
        .err_pulse(u2_err_pulse), .dup_cnt(u2_dup_cnt), .init_done(u2_init_done)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
        end
    endtask

    // Table model: operations complete atomically at acceptance; busy counts the cycles the port stays closed.
    int  m_mem [N];
    int  m_init, m_busy, m_qc, m_lc, m_la, m_dup, e_rc, e_ra;
    bit  m_qp, m_lv, e_err, e_rv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_init = N; m_busy = 0; m_qp = 0; m_lv = 0; m_dup = 0;
            e_err = 0; e_rv = 0; e_rc = 0; e_ra = 0;
        end else begin
            e_err = 0;
            e_rv  = 0;
            if (m_init > 0) m_init--;
            else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0 && m_qp) begin
                    e_rv = 1; e_rc = m_qc; e_ra = m_mem[m_qc]; m_qp = 0;
                end
            end else if (upd_valid) begin
                if (!upd_mode && m_lv && int'(upd_client) == m_lc && int'(upd_amount) == m_la)
                    m_dup = m_dup == 65535 ? m_dup : m_dup + 1;
                else begin
                    m_mem[upd_client] = upd_mode ? ((m_mem[upd_client] + int'(upd_amount) > 65535) ? 65535
                                                    : m_mem[upd_client] + int'(upd_amount))
                                                 : int'(upd_amount);
                    m_lv = 1; m_lc = upd_client; m_la = upd_amount; m_busy = 2;
                end
            end else if (qry_valid) begin
                m_busy = 1; m_qp = 1; m_qc = qry_client;
            end
        end
    end

    always @(negedge clk) begin
        chk("upd_ready",  upd_ready,  m_init == 0 && m_busy == 0);
        chk("qry_ready",  qry_ready,  m_init == 0 && m_busy == 0 && !upd_valid);
        chk("init_done",  init_done,  m_init == 0);
        chk("rsp_valid",  rsp_valid,  e_rv);
        chk("rsp_client", rsp_client, e_rc);
        chk("rsp_amount", rsp_amount, e_ra);
        chk("err_pulse",  err_pulse,  e_err);
        chk("dup_cnt",    dup_cnt,    m_dup);
    end

    always @(posedge clk) if (init_done && dut.u_ram.we) d_writes++;

    task automatic upd(input logic [4:0] c, input logic [15:0] a, input logic m);
        bit ok = 0;
        upd_valid = 1; upd_client = c; upd_amount = a; upd_mode = m;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = upd_ready; end
        chk("upd_accept", ok, 1);
        @(posedge clk); #1 upd_valid = 0;
    endtask

    task automatic qry(input logic [4:0] c, input logic [15:0] e, input string n);
        bit ok = 0;
        int lat = -1;
        qry_valid = 1; qry_client = c;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = qry_ready; end
        chk({n, "_accept"}, ok, 1);
        @(posedge clk); #1 qry_valid = 0;
        for (int i = 0; i < 5 && lat < 0; i++) begin @(negedge clk); if (rsp_valid) lat = i; end
        chk({n, "_lat"}, lat, 1);
        chk({n, "_amt"}, rsp_amount, e);
        chk({n, "_cli"}, rsp_client, c);
        @(posedge clk); #1;
    endtask

    task automatic upd2(input logic [4:0] c, input logic [15:0] a);
        u2_upd_valid = 1; u2_upd_client = c; u2_upd_amount = a;
        @(negedge clk); chk("u2_upd_ready", u2_upd_ready, 1);
        @(posedge clk); #1 u2_upd_valid = 0;
    endtask

    task automatic qry2(input logic [4:0] c);
        u2_qry_valid = 1; u2_qry_client = c;
        @(negedge clk); chk("u2_qry_ready", u2_qry_ready, 1);
        @(posedge clk); #1 u2_qry_valid = 0;
    endtask

    initial begin
        int w0;
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (31) @(posedge clk);
        @(negedge clk); chk("init_lo_31", init_done, 0);
        @(posedge clk);
        @(negedge clk); chk("init_hi_32", init_done, 1);
        @(posedge clk); #1;
        qry(31, 16'h0000, "q31_init");
        upd(5, 16'h0010, 0);
        qry(5, 16'h0010, "q5_ovw");
        upd(7, 16'hFFF0, 1);
        upd(7, 16'h0020, 1);
        qry(7, 16'hFFFF, "q7_sat");
        upd(3, 16'h0042, 0);
        repeat (2) @(posedge clk);
        #1 w0 = d_writes;
        upd(3, 16'h0042, 0);
        @(negedge clk); chk("dup_one", dup_cnt, 1); chk("dup_ready", upd_ready, 1);
        repeat (3) @(posedge clk);
        #1 chk("dup_no_write", d_writes, w0);
        upd(3, 16'h0043, 0);
        repeat (3) @(posedge clk);
        #1 chk("new_write", d_writes, w0 + 1);
        chk("dup_still_one", dup_cnt, 1);
        qry(3, 16'h0043, "q3_new");
        upd_valid = 1; upd_client = 12; upd_amount = 16'h0777; upd_mode = 0;
        qry_valid = 1; qry_client = 12;
        @(negedge clk); chk("sim_upd_ready", upd_ready, 1); chk("sim_qry_ready", qry_ready, 0);
        @(posedge clk); #1 upd_valid = 0;
        qry(12, 16'h0777, "q12_sim");
        upd(9, 16'h0055, 0);
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk); chk("rst_init_done", init_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = init_done; end
        chk("reinit_done", ok, 1);
        @(posedge clk); #1;
        qry(9, 16'h0000, "q9_after_rst");
        qry(5, 16'h0000, "q5_after_rst");
        chk("u2_init", u2_init_done, 1);
        upd2(25, 16'h1234);
        @(negedge clk); chk("u2_err_upd", u2_err_pulse, 1); chk("u2_stay_idle", u2_upd_ready, 1);
        @(negedge clk); chk("u2_err_clear", u2_err_pulse, 0);
        @(posedge clk); #1;
        qry2(25);
        @(negedge clk); chk("u2_err_qry", u2_err_pulse, 1); chk("u2_no_rsp0", u2_rsp_valid, 0);
        @(negedge clk); chk("u2_no_rsp1", u2_rsp_valid, 0); chk("u2_qry_idle", u2_qry_ready, 1);
        @(posedge clk); #1;
        upd2(19, 16'h0ABC);
        repeat (3) @(posedge clk);
        #1 qry2(19);
        @(negedge clk); chk("u2_qrd_no_rsp", u2_rsp_valid, 0);
        @(negedge clk); chk("u2_rsp19", u2_rsp_valid, 1);
        chk("u2_amt19", u2_rsp_amount, 16'h0ABC); chk("u2_cli19", u2_rsp_client, 19);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
